// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and helpers for the pipelined ripple adder.
//   DEF_WIDTH  - default operand/sum width
//   DEF_STAGES - default pipeline depth
//   slice_w()  - bits handled by each stage (WIDTH / STAGES)
package adder_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_STAGES = 2;

    // Guarded against a zero stage count so elaboration reaches the
    // parameter checks in the top instead of dividing by zero here.
    function automatic int slice_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/fa_cell.sv
// fa_cell: one-bit full adder made of two half adders and an OR.
//   a, b - operand bits
//   ci   - carry in
//   s    - sum bit
//   co   - carry out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic hs0, hc0, hc1;

    // first half adder: a + b
    assign hs0 = a ^ b;
    assign hc0 = a & b;
    // second half adder: partial sum + ci
    assign s   = hs0 ^ ci;
    assign hc1 = hs0 & ci;

    assign co  = hc0 | hc1;
endmodule

// File: rtl/pipe_ripple_adder.sv
// pipe_ripple_adder: WIDTH-bit unsigned adder split into STAGES ripple
// slices of SLICE bits each, with valid/ready handshaking on both sides.
//   clk, rst_n          - clock, async active-low reset
//   in_valid/in_ready   - input handshake for A, B, Cin
//   A, B, Cin           - operands and carry into bit 0
//   out_valid/out_ready - output handshake for Sum, Carry (and Ovf)
//   Sum, Carry          - A + B + Cin mod 2^WIDTH, carry out of the MSB
//   Ovf                 - signed overflow, only when ADDER_OVF_EN is defined
//
// Each stage register holds a WIDTH-bit word whose low bits are the sum
// slices completed so far and whose high bits are the A slices still to be
// added; the remaining B slices ride along right-justified in a separate
// register that shrinks by SLICE bits per stage.
module pipe_ripple_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry
`ifdef ADDER_OVF_EN
    ,
    output logic             Ovf
`endif
);
    localparam int SLICE = slice_w(WIDTH, STAGES);

    if (WIDTH < 2) begin : g_chk_width
        $error("pipe_ripple_adder: WIDTH must be >= 2");
    end
    if (STAGES < 1) begin : g_chk_stages
        $error("pipe_ripple_adder: STAGES must be >= 1");
    end
    if ((STAGES >= 1) && (WIDTH % STAGES != 0)) begin : g_chk_div
        $error("pipe_ripple_adder: WIDTH must be a multiple of STAGES");
    end

    // index 0 is the input side, index k+1 is the register of stage k
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0]            rdy;
    logic [STAGES:0]            cy_pipe;
    logic [STAGES:0][WIDTH-1:0] sa_pipe;

`ifdef ADDER_OVF_EN
    logic ovf_q;
    assign Ovf = ovf_q;
`endif

    assign vld_pipe[0] = in_valid;
    assign cy_pipe[0]  = Cin;
    assign sa_pipe[0]  = A;
    assign rdy[STAGES] = out_ready;
    assign in_ready    = rdy[0];

    assign out_valid   = vld_pipe[STAGES];
    assign Sum         = sa_pipe[STAGES];
    assign Carry       = cy_pipe[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO  = k * SLICE;
        localparam int REM = WIDTH - LO;

        logic [REM-1:0]   b_in;
        logic [SLICE:0]   c;
        logic [SLICE-1:0] s_sl;
        logic [WIDTH-1:0] sa_d;
        logic             ld;
        logic             vld_q;
        logic             cy_q;
        logic [WIDTH-1:0] sa_q;

        if (k == 0) begin : g_bin_first
            assign b_in = B;
        end else begin : g_bin_next
            assign b_in = g_stg[k-1].g_bq.b_q;
        end

        // a stage may take new data when empty or when it drains this cycle,
        // which lets bubbles collapse
        assign rdy[k] = !vld_pipe[k+1] || rdy[k+1];
        assign ld     = rdy[k] && vld_pipe[k];

        assign c[0] = cy_pipe[k];
        for (genvar i = 0; i < SLICE; i++) begin : g_fa
            fa_cell u_fa (
                .a  (sa_pipe[k][LO+i]),
                .b  (b_in[i]),
                .ci (c[i]),
                .s  (s_sl[i]),
                .co (c[i+1])
            );
        end

        always_comb begin
            sa_d             = sa_pipe[k];
            sa_d[LO +: SLICE] = s_sl;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                sa_q  <= '0;
            end else begin
                if (rdy[k]) vld_q <= vld_pipe[k];
                if (ld) begin
                    cy_q <= c[SLICE];
                    sa_q <= sa_d;
                end
            end
        end

        // B slices not yet consumed; the last stage has none left
        if (k < STAGES - 1) begin : g_bq
            logic [REM-SLICE-1:0] b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  b_q <= '0;
                else if (ld) b_q <= b_in[REM-1:SLICE];
            end
        end

`ifdef ADDER_OVF_EN
        // the MSBs of A and B are still unconsumed on entry to the last stage
        if (k == STAGES - 1) begin : g_ovf
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)  ovf_q <= 1'b0;
                else if (ld) ovf_q <= (sa_pipe[k][WIDTH-1] == b_in[REM-1]) &&
                                      (s_sl[SLICE-1] != sa_pipe[k][WIDTH-1]);
            end
        end
`endif

        assign vld_pipe[k+1] = vld_q;
        assign cy_pipe[k+1]  = cy_q;
        assign sa_pipe[k+1]  = sa_q;
    end

endmodule

// File: tb/tb_pipe_ripple_adder.sv
// tb_pipe_ripple_adder: scoreboard bench for pipe_ripple_adder (WIDTH=8,
// STAGES=2). Expected results are queued on input transfer and compared on
// output transfer. Define ADDER_OVF_EN to also check Ovf.
module tb_pipe_ripple_adder;

    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] Sum;
    logic       Carry;
`ifdef ADDER_OVF_EN
    logic       Ovf;
`endif

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   out_cnt = 0;
    logic mid_watch = 1'b0;
    logic seen30    = 1'b0;

    always #5 clk = ~clk;

    pipe_ripple_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Carry     (Carry)
`ifdef ADDER_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // drive one operation and hold it until accepted; returns stalled cycles
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int stalls);
        exp_t       e;
        logic [8:0] full;
        stalls   = 0;
        A        = a;
        B        = b;
        Cin      = c;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && stalls < 500) begin
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("send_timeout", 0, 1);
        end else begin
            full    = {1'b0, a} + {1'b0, b} + {8'd0, c};
            e.sum   = full[7:0];
            e.carry = full[8];
            e.ovf   = (a[7] == b[7]) && (full[7] != a[7]);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard compare
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mid_watch && out_valid && Sum == 8'h30) seen30 = 1'b1;
            if (rst_n && out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sum", Sum, e.sum);
                    chk("carry", Carry, e.carry);
`ifdef ADDER_OVF_EN
                    chk("ovf", Ovf, e.ovf);
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        int st;
        int st3;
        int tot;
        int n0;

        // reset with in_valid asserted
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        A         = 8'hAA;
        B         = 8'h55;
        Cin       = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", Sum, 8'h00);
        chk("rst_carry", Carry, 0);
`ifdef ADDER_OVF_EN
        chk("rst_ovf", Ovf, 0);
`endif
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // wrap cases, with latency check on the first
        send(8'hFF, 8'h01, 1'b0, st);
        @(negedge clk);
        chk("lat_cycle1_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid, 1);
        @(posedge clk);
        #1;
        send(8'hFF, 8'hFF, 1'b1, st);
        drain();

`ifdef ADDER_OVF_EN
        send(8'h7F, 8'h01, 1'b0, st);
        send(8'h80, 8'h80, 1'b0, st);
        drain();
`endif

        // backpressure: two accepts fill the pipe, third waits
        out_ready = 1'b0;
        send(8'h01, 8'h02, 1'b0, st);
        chk("stall_first_accept", st, 0);
        send(8'h03, 8'h04, 1'b0, st);
        chk("stall_second_accept", st, 0);
        fork
            send(8'h05, 8'h06, 1'b0, st3);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_in_ready", in_ready, 0);
                    chk("hold_out_valid", out_valid, 1);
                    chk("hold_sum", Sum, 8'h03);
                    chk("hold_carry", Carry, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        chk("third_was_stalled", (st3 >= 3), 1);
        drain();

        // reset while an operation is in flight
        n0        = out_cnt;
        mid_watch = 1'b1;
        send(8'h10, 8'h20, 1'b0, st);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_30", seen30, 0);
        chk("mid_rst_no_out", out_cnt - n0, 0);
        mid_watch = 1'b0;
        @(posedge clk);
        #1;

        // streaming: 100 random operations, out_ready held high
        n0  = out_cnt;
        tot = 0;
        for (int i = 0; i < 100; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), st);
            tot += st;
        end
        chk("stream_stalls", tot, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("stream_outs", out_cnt - n0, 100);
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
